// File: rtl/fir_decimator_mc.sv
// Time-multiplexed multi-channel decimating FIR with one shared MAC.
// Each channel keeps a circular sample history. Coefficients are loadable
// at run time while the block is idle. Results are rounded half-up and
// saturated to the sample width.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | accepting frames; a frame that completes DECIM starts MAC
//   S_MAC  | one product per cycle, channel-major then tap-major
//   S_OUT  | one-cycle out_valid pulse, then back to S_IDLE
module fir_decimator_mc #(
  parameter int IW        = 16,
  parameter int CW        = 16,
  parameter int COEF_FRAC = 15,
  parameter int TAPS      = 20,
  parameter int CHANNELS  = 2,
  parameter int DECIM     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHANNELS*IW-1:0] in_data,
  input  logic                   coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CW-1:0]          coef_data,
  output logic                   out_valid,
  output logic [CHANNELS*IW-1:0] out_data
);

  localparam int AW    = $clog2(TAPS);
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int ACC_W = IW + CW + $clog2(TAPS);
  localparam int GW    = ACC_W - IW - CW;

  localparam logic signed [CW-1:0] H0_RST = CW'((2 ** COEF_FRAC) - 1);
  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W - COEF_FRAC + 1){1'b0}}, 1'b1, {(COEF_FRAC - 1){1'b0}}};
  localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W - IW + 2){1'b0}}, {(IW - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t r_state, w_state_nxt;

  logic signed [CW-1:0]    r_coef [TAPS];
  logic signed [IW-1:0]    r_hist [CHANNELS][TAPS];
  logic [AW-1:0]           r_wptr, r_rptr, r_tap;
  logic [CHW-1:0]          r_ch;
  logic [PHW-1:0]          r_phase;
  logic signed [ACC_W-1:0] r_acc;

  logic [AW-1:0]            w_newest, w_rptr_dec, w_wptr_inc;
  logic signed [IW-1:0]     w_x, w_sat;
  logic signed [CW-1:0]     w_h;
  logic signed [IW+CW-1:0]  w_x_ext, w_h_ext, w_prod;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W:0]    w_rnd, w_shr;
  logic                     w_accept, w_wrap, w_last_tap, w_last, w_coef_wr;

  assign w_accept   = in_valid && in_ready && !clear;
  assign w_wrap     = (r_phase == PHW'(DECIM - 1));
  assign w_last_tap = (r_tap == AW'(TAPS - 1));
  assign w_last     = w_last_tap && (r_ch == CHW'(CHANNELS - 1));
  assign w_coef_wr  = coef_we && in_ready && !clear && (int'(coef_addr) < TAPS);

  // r_wptr points at the next slot to write, so the newest sample sits one behind it
  assign w_newest   = (r_wptr == '0) ? AW'(TAPS - 1) : r_wptr - AW'(1);
  assign w_rptr_dec = (r_rptr == '0) ? AW'(TAPS - 1) : r_rptr - AW'(1);
  assign w_wptr_inc = (r_wptr == AW'(TAPS - 1)) ? '0 : r_wptr + AW'(1);

  assign w_x       = r_hist[r_ch][r_rptr];
  assign w_h       = r_coef[r_tap];
  assign w_x_ext   = {{CW{w_x[IW-1]}}, w_x};
  assign w_h_ext   = {{IW{w_h[CW-1]}}, w_h};
  assign w_prod    = w_x_ext * w_h_ext;
  assign w_acc_sum = r_acc + {{GW{w_prod[IW+CW-1]}}, w_prod};
  assign w_rnd     = {w_acc_sum[ACC_W-1], w_acc_sum} + RND;
  assign w_shr     = w_rnd >>> COEF_FRAC;

  // Clip the rounded accumulator into the output sample range
  always_comb begin
    w_sat = w_shr[IW-1:0];
    if (w_shr > SAT_HI)      w_sat = SAT_HI[IW-1:0];
    else if (w_shr < SAT_LO) w_sat = SAT_LO[IW-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; clear overrides everything
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept && w_wrap) w_state_nxt = S_MAC;
      end
      S_MAC:   if (w_last) w_state_nxt = S_OUT;
      S_OUT: begin
        out_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  // Coefficients, history, decimation phase and MAC datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= (k == 0) ? H0_RST : '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) r_hist[c][k] <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_tap    <= '0;
      r_ch     <= '0;
      r_phase  <= '0;
      r_acc    <= '0;
      out_data <= '0;
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) r_hist[c][k] <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_tap    <= '0;
      r_ch     <= '0;
      r_phase  <= '0;
      r_acc    <= '0;
      out_data <= '0;
    end else begin
      if (w_coef_wr) r_coef[coef_addr] <= coef_data;
      if (w_accept) begin
        for (int c = 0; c < CHANNELS; c++) r_hist[c][r_wptr] <= in_data[c*IW +: IW];
        r_wptr  <= w_wptr_inc;
        r_rptr  <= r_wptr;
        r_phase <= w_wrap ? '0 : r_phase + PHW'(1);
        r_tap   <= '0;
        r_ch    <= '0;
        r_acc   <= '0;
      end
      if (r_state == S_MAC) begin
        if (w_last_tap) begin
          out_data[r_ch*IW +: IW] <= w_sat;
          r_acc  <= '0;
          r_tap  <= '0;
          r_ch   <= r_ch + CHW'(1);
          r_rptr <= w_newest;
        end else begin
          r_acc  <= w_acc_sum;
          r_tap  <= r_tap + AW'(1);
          r_rptr <= w_rptr_dec;
        end
      end
    end
  end

endmodule
